// File: rtl/div_share_pkg.sv
// rtl/div_share_pkg.sv - shared constants and types for the divider sharing controller
// Purpose: data width, FSM state encodings, lane indices and the latched-operand record
//   used by div_share_ctrl and div_reuse_buf.
// Ports: none (package).
package div_share_pkg;

  localparam int DATA_W = 32;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Lane indices; lane 0 is older in program order and wins ties
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef struct packed {
    logic              sign;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
  } div_ops_t;

endpackage

// File: rtl/div_reuse_buf.sv
// rtl/div_reuse_buf.sv - one-entry operand/result buffer for divider result reuse
// Purpose: remembers the operands and result of the last accepted divide so that a
//   repeat request on identical operands (div.w/mod.w pair) skips the divider.
//   Only instantiated when DIV_SHARE_REUSE_EN is defined.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset (clears the entry)
//   i_wr_en                    store i_wr_ops/i_wr_quot/i_wr_rem this cycle
//   i_wr_ops                   operands of the completing divide
//   i_wr_quot, i_wr_rem        result of the completing divide
//   i_lk_ops                   operands of the lane about to be granted
//   o_hit                      entry valid and operands match
//   o_quot, o_rem              stored result
module div_reuse_buf
  import div_share_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  div_ops_t          i_wr_ops,
  input  logic [DATA_W-1:0] i_wr_quot,
  input  logic [DATA_W-1:0] i_wr_rem,
  input  div_ops_t          i_lk_ops,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem
);

  logic              r_valid;
  div_ops_t          r_ops;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;

  // Flush never clears the entry: the result is a pure function of the operands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_ops   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else if (i_wr_en) begin
      r_valid <= 1'b1;
      r_ops   <= i_wr_ops;
      r_quot  <= i_wr_quot;
      r_rem   <= i_wr_rem;
    end
  end

  assign o_hit  = r_valid && (r_ops == i_lk_ops);
  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - arbitration and sequencing of one divider shared by two EX lanes
// Purpose: grants lane 0/1 divide requests (lane 0 first), latches the winner's operands,
//   starts or cancels the divider, and holds the result for the owning lane until it
//   leaves EX. Build option DIV_SHARE_REUSE_EN adds a one-entry result buffer.
// Ports:
//   clk, rst_n                                  clock, asynchronous active-low reset
//   flush_i                                     kills both lanes' EX instructions
//   div0_req_i/div1_req_i, div0_sign_i/div1_sign_i,
//   dividend0_i/dividend1_i, divisor0_i/divisor1_i   lane requests and operands
//   div0_ack_i/div1_ack_i                       lane instruction moved to MEM
//   div0_complete_o/div1_complete_o             result valid for that lane (level)
//   quotient_o, remainder_o                     shared held result
//   div_start_o, div_cancel_o                   one-cycle divider command pulses
//   div_sign_o, dividend_o, divisor_o           latched operands to the divider
//   div_done_i, quotient_i, remainder_i         divider completion and result
module div_share_ctrl
  import div_share_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              div0_req_i,
  input  logic              div1_req_i,
  input  logic              div0_sign_i,
  input  logic              div1_sign_i,
  input  logic [DATA_W-1:0] dividend0_i,
  input  logic [DATA_W-1:0] dividend1_i,
  input  logic [DATA_W-1:0] divisor0_i,
  input  logic [DATA_W-1:0] divisor1_i,
  input  logic              div0_ack_i,
  input  logic              div1_ack_i,
  output logic              div0_complete_o,
  output logic              div1_complete_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              div_start_o,
  output logic              div_cancel_o,
  output logic              div_sign_o,
  output logic [DATA_W-1:0] dividend_o,
  output logic [DATA_W-1:0] divisor_o,
  input  logic              div_done_i,
  input  logic [DATA_W-1:0] quotient_i,
  input  logic [DATA_W-1:0] remainder_i
);

  logic [1:0]        r_state;
  logic              r_owner;
  div_ops_t          r_ops;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic              r_complete0;
  logic              r_complete1;
  logic              r_start;
  logic              r_cancel;

  div_ops_t          w_ops0;
  div_ops_t          w_ops1;
  div_ops_t          w_grant_ops;
  logic              w_any_req;
  logic              w_grant_lane;
  logic              w_owner_req;
  logic              w_owner_ack;
  logic              w_done_ok;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_quot;
  logic [DATA_W-1:0] w_hit_rem;

  assign w_ops0       = {div0_sign_i, dividend0_i, divisor0_i};
  assign w_ops1       = {div1_sign_i, dividend1_i, divisor1_i};
  assign w_any_req    = div0_req_i | div1_req_i;
  assign w_grant_lane = div0_req_i ? LANE0 : LANE1;
  assign w_grant_ops  = div0_req_i ? w_ops0 : w_ops1;
  assign w_owner_req  = (r_owner == LANE1) ? div1_req_i : div0_req_i;
  assign w_owner_ack  = (r_owner == LANE1) ? div1_ack_i : div0_ack_i;

  // A done pulse is only taken while the owner still wants the result; a flush or a
  // dropped request in the same cycle means the operation is already abandoned.
  assign w_done_ok = (r_state == ST_BUSY) && !flush_i && w_owner_req && div_done_i;

`ifdef DIV_SHARE_REUSE_EN
  div_reuse_buf u_reuse_buf (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (w_done_ok),
    .i_wr_ops  (r_ops),
    .i_wr_quot (quotient_i),
    .i_wr_rem  (remainder_i),
    .i_lk_ops  (w_grant_ops),
    .o_hit     (w_hit),
    .o_quot    (w_hit_quot),
    .o_rem     (w_hit_rem)
  );
`else
  assign w_hit      = 1'b0;
  assign w_hit_quot = '0;
  assign w_hit_rem  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= LANE0;
      r_ops       <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_complete0 <= 1'b0;
      r_complete1 <= 1'b0;
      r_start     <= 1'b0;
      r_cancel    <= 1'b0;
    end else begin
      r_start  <= 1'b0;
      r_cancel <= 1'b0;
      if (flush_i) begin
        // Only an operation in flight on the divider needs aborting.
        r_cancel    <= (r_state == ST_BUSY);
        r_state     <= ST_IDLE;
        r_complete0 <= 1'b0;
        r_complete1 <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_any_req) begin
              r_owner <= w_grant_lane;
              r_ops   <= w_grant_ops;
              if (w_hit) begin
                // Identical operands to the buffered divide: answer without the divider.
                r_state     <= ST_DONE;
                r_quot      <= w_hit_quot;
                r_rem       <= w_hit_rem;
                r_complete0 <= (w_grant_lane == LANE0);
                r_complete1 <= (w_grant_lane == LANE1);
              end else begin
                r_state <= ST_BUSY;
                r_start <= 1'b1;
              end
            end
          end
          ST_BUSY: begin
            if (!w_owner_req) begin
              // Owner left EX without the result (e.g. killed upstream): abort.
              r_cancel <= 1'b1;
              r_state  <= ST_IDLE;
            end else if (w_done_ok) begin
              r_quot      <= quotient_i;
              r_rem       <= remainder_i;
              r_state     <= ST_DONE;
              r_complete0 <= (r_owner == LANE0);
              r_complete1 <= (r_owner == LANE1);
            end
          end
          ST_DONE: begin
            if (w_owner_ack) begin
              r_state     <= ST_IDLE;
              r_complete0 <= 1'b0;
              r_complete1 <= 1'b0;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_complete0 <= 1'b0;
            r_complete1 <= 1'b0;
          end
        endcase
      end
    end
  end

  assign div0_complete_o = r_complete0;
  assign div1_complete_o = r_complete1;
  assign quotient_o      = r_quot;
  assign remainder_o     = r_rem;
  assign div_start_o     = r_start;
  assign div_cancel_o    = r_cancel;
  assign div_sign_o      = r_ops.sign;
  assign dividend_o      = r_ops.dividend;
  assign divisor_o       = r_ops.divisor;

endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Sequencing and sharing controller for the single iterative 32-bit divider used by the two EX lanes of the dual-issue pipeline. It arbitrates divide/modulo requests from lane 0 (older) and lane 1, latches the winner's operands, starts and cancels the divider, and holds the result for the owning lane until that instruction leaves EX. It sits between the lanes' ALU divider ports and the divider core, and handles exception flushes mid-operation.

## Interface
- No parameters; data width is fixed at 32 bits.
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- flush_i  in  1  exception/refetch flush; kills both lanes' EX instructions
- div0_req_i / div1_req_i  in  1  lane divide request, level, held while the instruction waits in EX
- div0_sign_i / div1_sign_i  in  1  1 = signed divide
- dividend0_i / dividend1_i  in  32  lane dividend
- divisor0_i / divisor1_i  in  32  lane divisor
- div0_ack_i / div1_ack_i  in  1  lane's EX instruction moved to MEM this cycle
- div0_complete_o / div1_complete_o  out  1  result valid for that lane, level
- quotient_o, remainder_o  out  32  shared result, valid while a complete_o is high
- div_start_o  out  1  one-cycle start pulse to the divider
- div_cancel_o  out  1  one-cycle abort pulse to the divider
- div_sign_o, dividend_o, divisor_o  out  1/32/32  latched operands, stable from start to done
- div_done_i  in  1  divider done pulse; quotient_i/remainder_i valid that cycle
- quotient_i, remainder_i  in  32  divider result

## Operation
- States: IDLE, BUSY, DONE. Registers: state, owner (1 bit), operand latches, result latches.
- IDLE, flush_i=0: grant lane 0 if div0_req_i, else lane 1 if div1_req_i; fixed priority (lane 0 is older in program order). Latch owner, sign and operands; go BUSY.
- BUSY: div_start_o=1 in the first BUSY cycle only. On div_done_i: latch quotient_i/remainder_i, go DONE.
- DONE: divN_complete_o = (owner==N); the other lane sees 0. On owner's ack_i: go IDLE.
- Flush: from any state go IDLE next cycle. From BUSY, div_cancel_o pulses; any div_done_i in the same cycle as or after the cancel is ignored.
- Owner's req drop in BUSY without flush: treated as a cancel (div_cancel_o pulse, go IDLE).
- Non-owner req during BUSY/DONE: waits; there is no preemption.
- Operand latches hold their value after completion; only a new grant updates them.
- Reset: state IDLE, owner 0; all outputs and latches 0.

## Timing
- Grant at cycle T (IDLE); div_start_o at T+1; divider done at T+1+N; complete_o high from T+2+N until ack.
- Ack in DONE → IDLE at next edge; the earliest next grant is one cycle later, giving one bubble between back-to-back divides.
- flush_i has priority over ack, done and grant in the same cycle.
- complete_o, quotient_o and remainder_o are register outputs. div_start_o and div_cancel_o are registered pulses.

## Configuration
- DIV_SHARE_REUSE_EN defined: a one-entry buffer stores {valid, sign, dividend, divisor, quotient, remainder}, written on every accepted div_done_i. A grant in IDLE whose sign and operands match a valid entry goes directly to DONE with the buffered result. There is no div_start_o, and complete_o is high at T+1. This covers div.w/mod.w pairs on the same operands. The entry is cleared only by reset; flush does not clear it.
- Undefined: every grant goes through BUSY and the divider.

## Structure
- Shared package: state enum (IDLE/BUSY/DONE), data-width constant 32, lane index constants.
- One sub-module, div_reuse_buf, holding the match and storage logic. It is instantiated only under DIV_SHARE_REUSE_EN.

## Test plan
- Lane 0 requests unsigned 100/7 with a divider model of N=4 → start at T+1, div0_complete_o at T+6, quotient 14, remainder 2; held until div0_ack_i.
- Both lanes request in the same cycle (lane 0 −9/2 signed, lane 1 9/2) → lane 0 completes first with −4 / −1. After ack plus one bubble, lane 1 completes with 4 / 1. div1_complete_o is never high early.
- flush_i in the second BUSY cycle → div_cancel_o pulse. A late div_done_i is ignored and no complete_o fires. A new lane 1 request then starts cleanly.
- rst_n asserted in DONE → all outputs 0 immediately (asynchronous). After release the state is IDLE and no stale complete_o appears.
- With DIV_SHARE_REUSE_EN: 100/7 completes, then a second request for 100/7 → complete_o at T+1, no div_start_o, results 14 / 2. A request for 100/8 starts the divider.
- Owner drops its req in BUSY → cancel pulse and return to IDLE; the waiting lane 1 is granted the following cycle.
